// File: rtl/leuk_nn_pkg.sv
// Shared types and constants for the leukemia classifier layer datapath.
// Covers the layer sequencer states, pipeline latencies and the Q2.14 fixed-point format.
package leuk_nn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int MAC_LAT     = 1;
  localparam int RELU_LAT    = 1;
  localparam int Q_INT_BITS  = 2;
  localparam int Q_FRAC_BITS = 14;
  localparam int Q_WIDTH     = Q_INT_BITS + Q_FRAC_BITS;

  // Address width for a memory of the given depth, never narrower than one bit
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/neuron_layer_ctrl_if.sv
// Bundles the layer sequencer's control, memory-address, MAC and output-buffer signals.
// The master modport is the sequencer side; the slave modport is the surrounding datapath.
interface neuron_layer_ctrl_if
  import leuk_nn_pkg::*;
#(
  parameter int dataWidth = Q_WIDTH,
  parameter int IN_AW     = 5,
  parameter int W_AW      = 10,
  parameter int N_AW      = 5
) ();

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [IN_AW-1:0]     in_addr;
  logic [W_AW-1:0]      w_addr;
  logic                 mac_en;
  logic                 mac_first;
  logic [dataWidth-1:0] relu_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [dataWidth-1:0] out_data;
  logic [N_AW-1:0]      out_addr;

  modport master (
    input  start, relu_in, out_ready,
    output busy, done, in_addr, w_addr, mac_en, mac_first,
           out_valid, out_data, out_addr
  );

  modport slave (
    output start, relu_in, out_ready,
    input  busy, done, in_addr, w_addr, mac_en, mac_first,
           out_valid, out_data, out_addr
  );

endinterface

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register that realigns control strobes with memory read data.
module ctrl_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_r [DEPTH];

  // Shift stage by stage; every stage clears on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        pipe_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      pipe_r[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        pipe_r[k] <= pipe_r[k-1];
      end
    end
  end

  assign dout = pipe_r[DEPTH-1];

endmodule

// File: rtl/neuron_layer_ctrl.sv
// Sequencer for one fully-connected layer: streams input/weight addresses, strobes
// the MAC, waits out the MAC+ReLU pipeline and hands each activation to the output buffer.
module neuron_layer_ctrl
  import leuk_nn_pkg::*;
#(
  parameter int dataWidth   = Q_WIDTH,
  parameter int NUM_INPUTS  = 30,
  parameter int NUM_NEURONS = 30,
  parameter int MEM_LAT     = 1,
  parameter int IN_AW       = addr_width(NUM_INPUTS),
  parameter int W_AW        = addr_width(NUM_INPUTS * NUM_NEURONS),
  parameter int N_AW        = addr_width(NUM_NEURONS)
) (
  input logic                 clk,
  input logic                 rst,
  neuron_layer_ctrl_if.master bus
);

  localparam int DRAIN_CYC = MEM_LAT + MAC_LAT + RELU_LAT;
  localparam int D_AW      = addr_width(DRAIN_CYC);
  localparam logic [IN_AW-1:0] LAST_IN = IN_AW'(NUM_INPUTS - 1);
  localparam logic [N_AW-1:0]  LAST_N  = N_AW'(NUM_NEURONS - 1);
  localparam logic [D_AW-1:0]  LAST_D  = D_AW'(DRAIN_CYC - 1);

  state_t               state_r;
  state_t               state_s;
  logic [D_AW-1:0]      drain_r;
  logic [N_AW-1:0]      n_r;
  logic [IN_AW-1:0]     in_addr_r;
  logic [W_AW-1:0]      w_addr_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 out_valid_r;
  logic [dataWidth-1:0] out_data_r;
  logic [N_AW-1:0]      out_addr_r;
  logic [1:0]           issue_s;
  logic [1:0]           mac_s;
  logic                 fetch_last_s;
  logic                 drain_last_s;
  logic                 xfer_s;

  assign fetch_last_s = (in_addr_r == LAST_IN);
  assign drain_last_s = (drain_r == LAST_D);
  assign xfer_s       = out_valid_r & bus.out_ready;
  // bit 1 marks the first product of a neuron, bit 0 is the plain issue strobe
  assign issue_s = {(state_r == FETCH) && (in_addr_r == {IN_AW{1'b0}}), (state_r == FETCH)};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.start) state_s = FETCH; else state_s = IDLE;
      FETCH:   if (fetch_last_s) state_s = DRAIN; else state_s = FETCH;
      DRAIN:   if (drain_last_s) state_s = WRITE; else state_s = DRAIN;
      WRITE: begin
        if (xfer_s) begin
          if (n_r == LAST_N) state_s = DONE; else state_s = FETCH;
        end else begin
          state_s = WRITE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Address counters, drain timer and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_r     <= {D_AW{1'b0}};
      n_r         <= {N_AW{1'b0}};
      in_addr_r   <= {IN_AW{1'b0}};
      w_addr_r    <= {W_AW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {dataWidth{1'b0}};
      out_addr_r  <= {N_AW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) busy_r <= 1'b1;
        end
        FETCH: begin
          // hold the last pair so w_addr stays frozen until the next neuron starts
          if (!fetch_last_s) begin
            in_addr_r <= in_addr_r + IN_AW'(1);
            w_addr_r  <= w_addr_r + W_AW'(1);
          end
        end
        DRAIN: begin
          if (drain_last_s) begin
            drain_r     <= {D_AW{1'b0}};
            out_data_r  <= bus.relu_in;
            out_addr_r  <= n_r;
            out_valid_r <= 1'b1;
          end else begin
            drain_r <= drain_r + D_AW'(1);
          end
        end
        WRITE: begin
          if (xfer_s) begin
            out_valid_r <= 1'b0;
            in_addr_r   <= {IN_AW{1'b0}};
            if (n_r == LAST_N) begin
              n_r      <= {N_AW{1'b0}};
              w_addr_r <= {W_AW{1'b0}};
              done_r   <= 1'b1;
            end else begin
              n_r      <= n_r + N_AW'(1);
              w_addr_r <= w_addr_r + W_AW'(1);
            end
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  ctrl_delay_line #(
    .DEPTH (MEM_LAT),
    .WIDTH (2)
  ) u_mac_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (issue_s),
    .dout (mac_s)
  );

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.in_addr   = in_addr_r;
  assign bus.w_addr    = w_addr_r;
  assign bus.mac_en    = mac_s[0];
  assign bus.mac_first = mac_s[1];
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_addr  = out_addr_r;

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Directed + randomized bench for neuron_layer_ctrl, checked against a cycle schedule
// derived from the layer timing rules (fetch, drain, write, done per neuron).
module tb_neuron_layer_ctrl;
  import leuk_nn_pkg::*;

  localparam int NI  = 4;
  localparam int NN  = 3;
  localparam int ML  = 1;
  localparam int NI2 = 1;
  localparam int ML2 = 3;

  logic        clk;
  logic        rst;
  int          errors;
  int          checks;
  int          m_n;
  logic [15:0] relu_base;

  neuron_layer_ctrl_if #(.dataWidth(16), .IN_AW(addr_width(NI)),
    .W_AW(addr_width(NI*NN)), .N_AW(addr_width(NN))) bus ();
  neuron_layer_ctrl_if #(.dataWidth(16), .IN_AW(addr_width(NI2)),
    .W_AW(addr_width(NI2*NN)), .N_AW(addr_width(NN))) bus2 ();

  neuron_layer_ctrl #(.dataWidth(16), .NUM_INPUTS(NI), .NUM_NEURONS(NN), .MEM_LAT(ML),
    .IN_AW(addr_width(NI)), .W_AW(addr_width(NI*NN)), .N_AW(addr_width(NN)))
  dut (.clk(clk), .rst(rst), .bus(bus));

  neuron_layer_ctrl #(.dataWidth(16), .NUM_INPUTS(NI2), .NUM_NEURONS(NN), .MEM_LAT(ML2),
    .IN_AW(addr_width(NI2)), .W_AW(addr_width(NI2*NN)), .N_AW(addr_width(NN)))
  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // ReLU stage model: activation of neuron n is base + n
  assign bus.relu_in  = relu_base + m_n[15:0];
  assign bus2.relu_in = 16'h0abc;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs1();
    return {3'b000, bus.busy, bus.done, bus.in_addr, bus.w_addr, bus.mac_en,
            bus.mac_first, bus.out_valid, bus.out_data, bus.out_addr};
  endfunction

  // One layer on the main DUT; stall_n/stall_len hold out_ready low in that neuron's
  // write phase, repulse re-pulses start in FETCH and DONE, rst_n resets in that neuron's drain
  task automatic run_layer(input logic [15:0] base, input bit rnd, input int stall_n,
                           input int stall_len, input bit repulse, input int rst_n);
    int n = 0;
    int t = 0;
    int cyc = 0;
    int stall_left = stall_len;
    bit fin = 1'b0;
    bit ready;
    bit wr;
    relu_base = base;
    m_n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    while (!fin) begin
      if (cyc > 600) begin
        chk("timeout", 32'(cyc), 32'd0);
        fin = 1'b1;
      end else if (n == NN) begin
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("busy_in_done", 32'(bus.busy), 32'd1);
        chk("w_addr_wrap", 32'(bus.w_addr), 32'd0);
        if (repulse) bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("done_low", 32'(bus.done), 32'd0);
        chk("busy_low", 32'(bus.busy), 32'd0);
        fin = 1'b1;
      end else begin
        wr = (t >= NI + ML + 2);
        chk("busy", 32'(bus.busy), 32'd1);
        chk("done_early", 32'(bus.done), 32'd0);
        if (t < NI) begin
          chk("in_addr", 32'(bus.in_addr), 32'(t));
          chk("w_addr", 32'(bus.w_addr), 32'(n * NI + t));
        end
        chk("mac_en", 32'(bus.mac_en), 32'(t >= ML && t < NI + ML));
        chk("mac_first", 32'(bus.mac_first), 32'(t == ML));
        chk("out_valid", 32'(bus.out_valid), 32'(wr));
        if (wr) begin
          chk("out_addr", 32'(bus.out_addr), 32'(n));
          chk("out_data", 32'(bus.out_data), 32'(base + 16'(n)));
          chk("w_addr_frozen", 32'(bus.w_addr), 32'(n * NI + NI - 1));
        end
        if (rst_n == n && t == NI) begin
          rst = 1'b1;
          #1;
          chk("rst_outputs", all_outs1(), 32'd0);
          @(negedge clk);
          rst = 1'b0;
          fin = 1'b1;
        end else begin
          if (rnd) ready = ($urandom_range(0, 1) == 1);
          else ready = !(n == stall_n && stall_left > 0 && wr);
          if (wr && !ready && stall_left > 0) stall_left--;
          bus.out_ready = ready;
          bus.start = repulse && n == 0 && t == 1;
          @(posedge clk);
          #1;
          bus.start = 1'b0;
          cyc++;
          if (wr && ready) begin
            n++;
            m_n = n;
            t = 0;
          end else begin
            t++;
          end
        end
      end
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_n = 0;
    relu_base = 16'h0000;
    clk = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    bus2.start = 1'b0;
    bus2.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs1(), 32'd0);
    chk("reset_outputs2", 32'({bus2.busy, bus2.done, bus2.mac_en, bus2.out_valid,
                               bus2.out_data}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // plain layer with known activations, then a 5-cycle stall in neuron 1
    run_layer(16'h1234, 1'b0, -1, 0, 1'b0, -1);
    run_layer(16'h1234, 1'b0, 1, 5, 1'b0, -1);
    // stray start pulses, then reset in neuron 2 drain followed by a clean layer
    run_layer(16'($urandom), 1'b0, -1, 0, 1'b1, -1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("idle_after_done", 32'({bus.busy, bus.done}), 32'd0);
    end
    run_layer(16'h0f00, 1'b0, -1, 0, 1'b0, 2);
    run_layer(16'h2000, 1'b0, -1, 0, 1'b0, -1);
    // random out_ready backpressure and random activations
    repeat (2) run_layer(16'($urandom), 1'b1, -1, 0, 1'b0, -1);

    // single-input layer, deep memory latency: 7 cycles per neuron
    @(negedge clk);
    bus2.start = 1'b1;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    for (int c = 0; c <= NN * (NI2 + ML2 + 3); c++) begin
      chk("n1_mac_en", 32'(bus2.mac_en), 32'(c < NN * 7 && c % 7 == ML2));
      chk("n1_mac_first", 32'(bus2.mac_first), 32'(c < NN * 7 && c % 7 == ML2));
      chk("n1_out_valid", 32'(bus2.out_valid), 32'(c < NN * 7 && c % 7 == 6));
      if (c < NN * 7 && c % 7 == 6) chk("n1_out_addr", 32'(bus2.out_addr), 32'(c / 7));
      chk("n1_done", 32'(bus2.done), 32'(c == NN * 7));
      @(posedge clk);
      #1;
    end
    chk("n1_idle", 32'({bus2.busy, bus2.done}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
